// File: rtl/fft_peak_analyzer.sv
// fft_peak_analyzer: captures one 16-bin FFT frame, scans it one bin per
// cycle for the largest re^2 + im^2, and reports that bin's index on freq
// with a one-cycle done pulse.
module fft_peak_analyzer #(
  parameter int DW  = 16,
  parameter int NPT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_valid,
  input  logic [2*DW-1:0]         fft_d0,
  input  logic [2*DW-1:0]         fft_d1,
  input  logic [2*DW-1:0]         fft_d2,
  input  logic [2*DW-1:0]         fft_d3,
  input  logic [2*DW-1:0]         fft_d4,
  input  logic [2*DW-1:0]         fft_d5,
  input  logic [2*DW-1:0]         fft_d6,
  input  logic [2*DW-1:0]         fft_d7,
  input  logic [2*DW-1:0]         fft_d8,
  input  logic [2*DW-1:0]         fft_d9,
  input  logic [2*DW-1:0]         fft_d10,
  input  logic [2*DW-1:0]         fft_d11,
  input  logic [2*DW-1:0]         fft_d12,
  input  logic [2*DW-1:0]         fft_d13,
  input  logic [2*DW-1:0]         fft_d14,
  input  logic [2*DW-1:0]         fft_d15,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NPT)-1:0]  freq
);

  localparam int AW = $clog2(NPT);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t                r_state;
  logic [2*DW-1:0]       w_in    [NPT];
  logic [2*DW-1:0]       r_frame [NPT];
  logic [AW-1:0]         r_cnt;
  logic [AW-1:0]         r_idx;
  logic [2*DW-1:0]       r_max;
  logic                  r_busy;
  logic                  r_done;
  logic [AW-1:0]         r_freq;
  logic                  w_capture;
  logic signed [DW-1:0]  w_re;
  logic signed [DW-1:0]  w_im;
  logic signed [2*DW-1:0] w_re_sq;
  logic signed [2*DW-1:0] w_im_sq;
  logic [2*DW-1:0]       w_mag;

  assign w_in[0]  = fft_d0;
  assign w_in[1]  = fft_d1;
  assign w_in[2]  = fft_d2;
  assign w_in[3]  = fft_d3;
  assign w_in[4]  = fft_d4;
  assign w_in[5]  = fft_d5;
  assign w_in[6]  = fft_d6;
  assign w_in[7]  = fft_d7;
  assign w_in[8]  = fft_d8;
  assign w_in[9]  = fft_d9;
  assign w_in[10] = fft_d10;
  assign w_in[11] = fft_d11;
  assign w_in[12] = fft_d12;
  assign w_in[13] = fft_d13;
  assign w_in[14] = fft_d14;
  assign w_in[15] = fft_d15;

  assign w_capture = (r_state == IDLE) && fft_valid;

  // Each square is non-negative and at most 2^30, so the unsigned sum
  // peaks at 2^31 and cannot wrap in 2*DW bits.
  assign w_re    = r_frame[r_cnt][2*DW-1:DW];
  assign w_im    = r_frame[r_cnt][DW-1:0];
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;
  assign w_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

  // Frame buffer: loaded only on an accepted strobe, never re-sampled during a scan.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int unsigned k = 0; k < NPT; k++) begin
        r_frame[k] <= w_in[k];
      end
    end
  end

  // Control FSM with registered busy/done/freq; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_freq  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (fft_valid) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (w_mag > r_max) begin
            r_max <= w_mag;
            r_idx <= r_cnt;
          end
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(NPT - 1)) begin
            r_state <= REPORT;
            r_busy  <= 1'b0;
          end
        end
        REPORT: begin
          r_done  <= 1'b1;
          r_freq  <= r_idx;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign freq = r_freq;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Self-checking bench for fft_peak_analyzer: directed cases plus random
// frames compared against a plain-arithmetic peak search.
module tb_fft_peak_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        busy;
  logic        done;
  logic [3:0]  freq;

  logic [31:0] frame   [16];
  logic [31:0] frame_b [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fft_peak_analyzer #(.DW(16), .NPT(16)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .busy(busy), .done(done), .freq(freq)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest re^2+im^2 over the frame, first occurrence wins, zero max start.
  function automatic logic [3:0] model_peak();
    longint best = 0;
    int     idx  = 0;
    for (int k = 0; k < 16; k++) begin
      longint re  = longint'($signed(frame[k][31:16]));
      longint im  = longint'($signed(frame[k][15:0]));
      longint mag = re * re + im * im;
      if (mag > best) begin
        best = mag;
        idx  = k;
      end
    end
    return 4'(idx);
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < 16; k++) frame[k] = 32'h0;
  endtask

  // Present frame, optionally inject frame_b at sample n, poke fft_valid on
  // the REPORT edge, or scramble inputs during the scan; then check results.
  task automatic run_frame(input string tag, input int inject_at,
                           input bit poke_report, input bit scramble);
    int         busy_cnt = 0;
    int         lat = -1;
    logic [3:0] exp_f;
    exp_f = model_peak();
    d = frame;
    fft_valid = 1'b1;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (done) lat = n;
      else begin
        if (busy) busy_cnt++;
        if (n == inject_at) begin
          d = frame_b;
          fft_valid = 1'b1;
        end else if (poke_report && n == 16) begin
          fft_valid = 1'b1;
        end else begin
          fft_valid = 1'b0;
        end
        if (scramble) for (int k = 0; k < 16; k++) d[k] = $urandom;
        @(posedge clk); #1;
      end
    end
    fft_valid = 1'b0;
    check({tag, ":latency"}, lat, 17);
    check({tag, ":busy_cycles"}, busy_cnt, 16);
    check({tag, ":freq"}, freq, exp_f);
    @(posedge clk); #1;
    check({tag, ":done_width"}, done, 0);
    check({tag, ":idle_busy"}, busy, 0);
    check({tag, ":freq_hold"}, freq, exp_f);
  endtask

  initial begin
    logic [15:0] small_vals [4];
    int          no_done;
    small_vals[0] = 16'h0000;
    small_vals[1] = 16'h0100;
    small_vals[2] = 16'hFF00;
    small_vals[3] = 16'h0200;

    rst = 1'b1;
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:busy", busy, 0);
    check("reset:done", done, 0);
    check("reset:freq", freq, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single peak
    clear_frame();
    frame[1] = {16'h0400, 16'h0000};
    run_frame("single_peak", -1, 1'b0, 1'b0);

    // Conjugate tie: lowest index wins
    clear_frame();
    for (int k = 0; k < 16; k++) frame[k] = {16'h0001, 16'h0001};
    frame[1]  = {16'h0300, 16'h0400};
    frame[15] = {16'h0300, 16'hFC00};
    run_frame("tie", -1, 1'b0, 1'b0);

    // Negative extremes, 2^31 magnitude must not wrap
    clear_frame();
    frame[7] = {16'h8000, 16'h8000};
    frame[3] = {16'h7FFF, 16'h7FFF};
    run_frame("neg_extreme", -1, 1'b0, 1'b0);

    // All-zero frame
    clear_frame();
    run_frame("all_zero", -1, 1'b0, 1'b0);

    // Overlap: B at 6 cycles is dropped, then B re-sent later is accepted
    for (int k = 0; k < 16; k++) frame_b[k] = 32'h0;
    frame_b[9] = {16'h0000, 16'h0500};
    clear_frame();
    frame[5] = {16'h0200, 16'h0200};
    run_frame("overlap_a", 5, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("overlap:hold", freq, 5);
    frame = frame_b;
    run_frame("overlap_b", -1, 1'b0, 1'b0);

    // Strobe on the REPORT->IDLE edge is not a capture
    clear_frame();
    frame[12] = {16'h0100, 16'h0000};
    run_frame("report_edge", -1, 1'b1, 1'b0);

    // Reset in the middle of a scan
    clear_frame();
    frame[4] = {16'h0700, 16'h0000};
    d = frame;
    fft_valid = 1'b1;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst:busy", busy, 0);
    check("midrst:done", done, 0);
    check("midrst:freq", freq, 0);
    no_done = 1;
    for (int n = 0; n < 25; n++) begin
      if (done || busy) no_done = 0;
      @(posedge clk); #1;
    end
    check("midrst:quiet", no_done, 1);
    clear_frame();
    frame[2] = {16'hFA00, 16'h0000};
    run_frame("after_rst", -1, 1'b0, 1'b0);

    // Randomized frames: full-range or small values (frequent ties), with
    // optional scrambled inputs and dropped overlapping strobes.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 16; k++) begin
        if (t % 2 == 0) frame[k] = $urandom;
        else frame[k] = {small_vals[$urandom_range(0, 3)], small_vals[$urandom_range(0, 3)]};
        frame_b[k] = $urandom;
      end
      run_frame($sformatf("rand%0d", t), (t % 3 == 0) ? int'($urandom_range(0, 15)) : -1,
                t[0], (t % 4 == 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_peak_analyzer.md
Name: fft_peak_analyzer

Overview:
- Analysis stage directly downstream of the 16-point FFT in the FAS chain.
- Captures one 16-bin FFT frame when fft_valid is asserted.
- Scans the bins serially and computes |X[k]|^2 = re^2 + im^2 for each bin.
- Reports the index of the strongest bin on freq, with a one-cycle done pulse.

Parameters:
- DW, 16, width of each real/imag component (signed, 8 integer + 8 fraction)
- NPT, 16, FFT points per frame (fixed at 16; freq is log2(NPT) = 4 bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- fft_valid  input  1  frame strobe; fft_d0..fft_d15 are valid in this cycle
- fft_d0 .. fft_d15  input  32 each  bin k; [31:16] signed real, [15:0] signed imag
- busy  output  1  high while a frame is held or being scanned
- done  output  1  one-cycle pulse; freq is valid in the same cycle
- freq  output  4  index of the maximum-magnitude bin

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, freq=0, state=IDLE, bin counter=0, running max=0, max index=0.
- States: IDLE -> SCAN -> REPORT -> IDLE.
- IDLE:
  - When fft_valid=1, latch all 16 words into the frame buffer, clear max and index, set cnt=0, go to SCAN.
  - busy rises in the cycle after the capture edge.
- SCAN: processes one bin per cycle, cnt = 0..15.
  - mag = re*re + im*im. Each product is a signed 16x16 giving 32 bits, treated as unsigned.
  - The sum is 32-bit unsigned with no overflow. Worst case is (-32768)^2 * 2 = 2^31.
  - Update max and index only if mag > max (strictly greater), so ties keep the lowest index.
  - Bin 0 with mag = 0 leaves index = 0.
  - After cnt = 15 is processed, go to REPORT.
- REPORT:
  - done=1 for exactly one cycle; freq <= max index, registered.
  - busy=0 in this cycle's output; return to IDLE.
- Latency: fft_valid sampled at edge T. Bins are processed on edges T+1..T+16. done and freq are visible after edge T+17, i.e. 17 cycles from capture to the done pulse.
- freq holds its value after done until the next REPORT or a reset.
- fft_valid while busy=1 or in REPORT: ignored, the frame is dropped and the captured frame is unaffected.
- fft_valid in the same cycle as the REPORT-to-IDLE transition: ignored. Only IDLE accepts a frame.
- The source must hold off at least 18 cycles between frames.
- Inputs are never re-sampled after capture; changes on fft_dk during SCAN have no effect.
- rst asserted in any state, including mid-SCAN:
  - Next cycle is IDLE, all outputs at their reset values, no done pulse.
  - A partial frame is discarded.
- The magnitude compare may be pipelined one stage, provided the 17-cycle done latency is preserved exactly.

Test Plan:
- Single peak: frame has bin 1 = {16'h0400, 16'h0000} and all other bins 0; fft_valid for 1 cycle. Required: done exactly 17 cycles later with freq=1; busy high for 16 cycles; done high for 1 cycle.
- Tie/conjugate symmetry: bin 1 = {16'h0300, 16'h0400} and bin 15 = {16'h0300, 16'hFC00} (equal magnitude), others small. Required: freq=1 (lowest index wins).
- Negative extremes: bin 7 = {16'h8000, 16'h8000} (mag 2^31), bin 3 = {16'h7FFF, 16'h7FFF}. Required: freq=7, with no overflow wrap.
- All-zero frame. Required: freq=0, done still pulses at cycle 17.
- Overlap:
  - Frame A (peak bin 5), then frame B (peak bin 9) presented 6 cycles later. Required: B is ignored and done gives freq=5.
  - B re-sent 20 cycles after A. Required: second done gives freq=9, and freq holds 5 between the two done pulses.
- Reset mid-scan: assert rst for 1 cycle at cycle 8 of SCAN. Required: no done, freq=0, busy=0 the next cycle. A new frame with peak bin 2 then yields freq=2 after 17 cycles.
